// File: rtl/multi_oneshot_timer.sv
// ---------------------------------------------------------------------------
// multi_oneshot_timer
//
// Purpose:
//   CHANNELS independent one-shot timers that share one free-running tick
//   prescaler. A start request arms a channel: led stays high for
//   `duration` ticks, then done pulses for one cycle. A channel can be
//   cancelled, and can optionally be retriggered while it is running. Each
//   channel's remaining tick count is visible on `remaining`.
//
// Parameters:
//   CLK_HZ    input clock frequency in Hz
//   TICK_HZ   tick rate; DIV = CLK_HZ / TICK_HZ (must be >= 1)
//   CHANNELS  number of independent timers
//   CNT_W     width of the duration / remaining counters
//   RETRIGGER 1 = start while running reloads duration, 0 = ignored
//
// Ports:
//   clock      in   system clock, all logic on posedge
//   resett     in   asynchronous active-high reset
//   start      in   [CHANNELS]        per-channel start request
//   cancel     in   [CHANNELS]        per-channel abort
//   duration   in   [CHANNELS*CNT_W]  tick count, channel i at [i*CNT_W +: CNT_W]
//   led        out  [CHANNELS]        high while the channel is running
//   done       out  [CHANNELS]        one-cycle pulse on natural expiry
//   remaining  out  [CHANNELS*CNT_W]  current count, 0 when idle
//
// Build option:
//   MULTI_ONESHOT_EDGE_START_EN  when defined, only a 0->1 edge on a start
//                                bit counts as a request (held buttons fire
//                                once); otherwise start is level-sensitive.
// ---------------------------------------------------------------------------
module multi_oneshot_timer #(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TICK_HZ   = 1,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned RETRIGGER = 0
) (
  input  logic                      clock,
  input  logic                      resett,
  input  logic [CHANNELS-1:0]       start,
  input  logic [CHANNELS-1:0]       cancel,
  input  logic [CHANNELS*CNT_W-1:0] duration,
  output logic [CHANNELS-1:0]       led,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS*CNT_W-1:0] remaining
);

  localparam int unsigned DIV       = CLK_HZ / TICK_HZ;
  localparam int unsigned PCNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
  localparam bit          RETRIG_EN = (RETRIGGER != 0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shared prescaler: free-running, never restarted by start.
  logic [PCNT_W-1:0] pcnt;
  logic              tick_c;

  // With DIV == 1 PCNT_MAX is 0, so pcnt stays 0 and tick is always high.
  assign tick_c = (pcnt == PCNT_MAX);

  always_ff @(posedge clock or posedge resett) begin
    if (resett) begin
      pcnt <= '0;
    end else if (tick_c) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  // Start request qualification (level or rising edge).
  logic [CHANNELS-1:0] start_req_c;

`ifdef MULTI_ONESHOT_EDGE_START_EN
  logic [CHANNELS-1:0] start_q;

  always_ff @(posedge clock or posedge resett) begin
    if (resett) begin
      start_q <= '0;
    end else begin
      start_q <= start;
    end
  end

  // Rising edge against last cycle's value, so no extra latency is added.
  assign start_req_c = start & ~start_q;
`else
  assign start_req_c = start;
`endif

  // Per-channel one-shot.
  for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
    state_t           state_q;
    state_t           state_n;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_n;
    logic [CNT_W-1:0] dur_c;
    logic             done_q;
    logic             done_n;

    assign dur_c = duration[i*CNT_W +: CNT_W];

    // State, count and done registers.
    always_ff @(posedge clock or posedge resett) begin
      if (resett) begin
        state_q <= IDLE;
        rem_q   <= '0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_n;
        rem_q   <= rem_n;
        done_q  <= done_n;
      end
    end

    // Next state: cancel > retrigger > tick while running.
    always_comb begin
      state_n = state_q;
      rem_n   = rem_q;
      done_n  = 1'b0;

      unique case (state_q)
        IDLE: begin
          // Cancel in the same cycle as start keeps the channel idle.
          if (!cancel[i] && start_req_c[i]) begin
            if (dur_c != '0) begin
              state_n = RUN;
              rem_n   = dur_c;
            end else begin
              done_n  = 1'b1;
            end
          end
        end

        RUN: begin
          if (cancel[i]) begin
            state_n = IDLE;
            rem_n   = '0;
          end else if (RETRIG_EN && start_req_c[i]) begin
            // Reload wins over an expiring tick; a zero reload expires.
            if (dur_c != '0) begin
              rem_n   = dur_c;
            end else begin
              state_n = IDLE;
              rem_n   = '0;
              done_n  = 1'b1;
            end
          end else if (tick_c) begin
            if (rem_q == CNT_W'(1)) begin
              state_n = IDLE;
              rem_n   = '0;
              done_n  = 1'b1;
            end else begin
              rem_n   = rem_q - CNT_W'(1);
            end
          end
        end

        default: begin
          state_n = IDLE;
          rem_n   = '0;
        end
      endcase
    end

    assign led[i]                       = (state_q == RUN);
    assign done[i]                      = done_q;
    assign remaining[i*CNT_W +: CNT_W]  = rem_q;
  end

endmodule

// File: tb/tb_multi_oneshot_timer.sv
// ---------------------------------------------------------------------------
// tb_multi_oneshot_timer
//
// Purpose:
//   Self-checking bench for multi_oneshot_timer with DIV=10, CHANNELS=2,
//   CNT_W=8. Two instances share all inputs: one with RETRIGGER=0 and one
//   with RETRIGGER=1. A reference model tracks each armed channel as a load
//   cycle plus an expiry cycle derived arithmetically from the tick phase,
//   and compares every output on every cycle.
// ---------------------------------------------------------------------------
module tb_multi_oneshot_timer;

  localparam int DIV  = 10;
  localparam int CH   = 2;
  localparam int W    = 8;
  localparam int HMAX = 80;

  logic          clock;
  logic          resett;
  logic [CH-1:0] start;
  logic [CH-1:0] cancel;
  logic [CH*W-1:0] duration;
  logic [CH-1:0] led_a, done_a, led_b, done_b;
  logic [CH*W-1:0] rem_a, rem_b;

  multi_oneshot_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .CHANNELS(CH), .CNT_W(W), .RETRIGGER(0)
  ) u_r0 (
    .clock(clock), .resett(resett), .start(start), .cancel(cancel),
    .duration(duration), .led(led_a), .done(done_a), .remaining(rem_a)
  );

  multi_oneshot_timer #(
    .CLK_HZ(10), .TICK_HZ(1), .CHANNELS(CH), .CNT_W(W), .RETRIGGER(1)
  ) u_r1 (
    .clock(clock), .resett(resett), .start(start), .cancel(cancel),
    .duration(duration), .led(led_b), .done(done_b), .remaining(rem_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, index [dut][channel]; dut 1 is the retriggerable one.
  int m_cycle;
  bit m_active [2][CH];
  int m_load   [2][CH];
  int m_dur    [2][CH];
  int m_k1     [2][CH];
  int m_expire [2][CH];
  int m_pulse  [2][CH];
  bit m_prev   [CH];

  // History of outputs per cycle for the directed scenarios.
  logic [CH-1:0] h_led  [2][HMAX];
  logic [CH-1:0] h_done [2][HMAX];
  logic [W-1:0]  h_rem0 [2][HMAX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // First tick cycle strictly after cycle c (ticks where cycle % DIV == DIV-1).
  function automatic int first_tick_after(input int c);
    int n;
    n = c + 1;
    return n + ((DIV - 1) - (n % DIV));
  endfunction

  function automatic int ticks_upto(input int k1, input int b);
    return (b < k1) ? 0 : ((b - k1) / DIV + 1);
  endfunction

  function automatic int exp_rem(input int d, input int ch);
    if (!m_active[d][ch]) return 0;
    return m_dur[d][ch] - ticks_upto(m_k1[d][ch], m_cycle - 1);
  endfunction

  task automatic model_reset();
    m_cycle = 0;
    for (int d = 0; d < 2; d++)
      for (int ch = 0; ch < CH; ch++) begin
        m_active[d][ch] = 1'b0;
        m_load[d][ch]   = 0;
        m_dur[d][ch]    = 0;
        m_k1[d][ch]     = 0;
        m_expire[d][ch] = 0;
        m_pulse[d][ch]  = -1;
      end
    for (int ch = 0; ch < CH; ch++) m_prev[ch] = 1'b0;
  endtask

  task automatic model_load(input int d, input int ch, input int c, input int dur);
    m_active[d][ch] = 1'b1;
    m_load[d][ch]   = c;
    m_dur[d][ch]    = dur;
    m_k1[d][ch]     = first_tick_after(c);
    m_expire[d][ch] = m_k1[d][ch] + (dur - 1) * DIV + 1;
  endtask

  // Advance the model by one clock using the inputs present this cycle.
  task automatic model_step();
    int c;
    int dur;
    bit req;
    c = m_cycle;
    for (int ch = 0; ch < CH; ch++) begin
      dur = int'(duration[ch*W +: W]);
`ifdef MULTI_ONESHOT_EDGE_START_EN
      req = start[ch] && !m_prev[ch];
`else
      req = start[ch];
`endif
      for (int d = 0; d < 2; d++) begin
        if (m_active[d][ch]) begin
          if (cancel[ch]) begin
            m_active[d][ch] = 1'b0;
          end else if (d == 1 && req) begin
            if (dur != 0) begin
              model_load(d, ch, c, dur);
            end else begin
              m_active[d][ch] = 1'b0;
              m_pulse[d][ch]  = c + 1;
            end
          end
        end else if (!cancel[ch] && req) begin
          if (dur != 0) model_load(d, ch, c, dur);
          else          m_pulse[d][ch] = c + 1;
        end
        if (m_active[d][ch] && m_expire[d][ch] == c + 1) begin
          m_active[d][ch] = 1'b0;
          m_pulse[d][ch]  = c + 1;
        end
      end
      m_prev[ch] = start[ch];
    end
    m_cycle++;
  endtask

  function automatic logic [CH-1:0] led_of(input int d);
    return (d == 0) ? led_a : led_b;
  endfunction
  function automatic logic [CH-1:0] done_of(input int d);
    return (d == 0) ? done_a : done_b;
  endfunction
  function automatic logic [CH*W-1:0] rem_of(input int d);
    return (d == 0) ? rem_a : rem_b;
  endfunction

  task automatic compare_all();
    logic [CH-1:0]   el, ed;
    logic [CH*W-1:0] er;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < CH; ch++) begin
        el[ch]         = m_active[d][ch];
        ed[ch]         = (m_pulse[d][ch] == m_cycle);
        er[ch*W +: W]  = W'(exp_rem(d, ch));
      end
      check($sformatf("model_led_r%0d c%0d", d, m_cycle), 32'(led_of(d)), 32'(el));
      check($sformatf("model_done_r%0d c%0d", d, m_cycle), 32'(done_of(d)), 32'(ed));
      check($sformatf("model_rem_r%0d c%0d", d, m_cycle), 32'(rem_of(d)), 32'(er));
    end
  endtask

  // Inputs for the current cycle are already applied; clock once and compare.
  task automatic step();
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    resett   = 1'b1;
    start    = '0;
    cancel   = '0;
    duration = '0;
    @(posedge clock);
    #1;
    resett = 1'b0;
    model_reset();
    compare_all();
  endtask

  task automatic record(input int idx);
    if (idx < HMAX) begin
      h_led[0][idx]  = led_a;  h_done[0][idx] = done_a;  h_rem0[0][idx] = rem_a[W-1:0];
      h_led[1][idx]  = led_b;  h_done[1][idx] = done_b;  h_rem0[1][idx] = rem_b[W-1:0];
    end
  endtask

  function automatic int first_done(input int d, input int ch, input int n);
    for (int i = 0; i < n; i++)
      if (h_done[d][i][ch]) return i;
    return -1;
  endfunction

  function automatic int count_done(input int d, input int ch, input int n);
    int k;
    k = 0;
    for (int i = 0; i < n; i++)
      if (h_done[d][i][ch]) k++;
    return k;
  endfunction

  // Cycle 0 is the first cycle after reset release (prescaler phase 0).
  task automatic scen_run(input bit do_rst, input int cancel_at, input int restart_at,
                          input int ncyc, input bit hold);
    if (do_rst) do_reset();
    record(0);
    for (int c = 0; c < ncyc; c++) begin
      if (hold) begin
        start    = (c < 50) ? 2'b01 : 2'b00;
        cancel   = 2'b00;
        duration = {8'd0, 8'd2};
      end else begin
        start    = (c == 0) ? 2'b11 : ((c == restart_at) ? 2'b01 : 2'b00);
        cancel   = (c == cancel_at) ? 2'b01 : 2'b00;
        duration = {8'd2, 8'd3};
      end
      step();
      record(c + 1);
    end
    start  = '0;
    cancel = '0;
  endtask

  task automatic basic_checks(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_done0_cycle_r%0d", tag, d), 32'(first_done(d, 0, 40)), 32'd30);
      check($sformatf("%s_done0_count_r%0d", tag, d), 32'(count_done(d, 0, 40)), 32'd1);
      check($sformatf("%s_done1_cycle_r%0d", tag, d), 32'(first_done(d, 1, 40)), 32'd20);
      check($sformatf("%s_led0_c0_r%0d", tag, d), 32'(h_led[d][0][0]), 32'd0);
      check($sformatf("%s_led0_c1_r%0d", tag, d), 32'(h_led[d][1][0]), 32'd1);
      check($sformatf("%s_led0_c29_r%0d", tag, d), 32'(h_led[d][29][0]), 32'd1);
      check($sformatf("%s_led0_c30_r%0d", tag, d), 32'(h_led[d][30][0]), 32'd0);
      check($sformatf("%s_rem0_c1_r%0d", tag, d), 32'(h_rem0[d][1]), 32'd3);
      check($sformatf("%s_rem0_c10_r%0d", tag, d), 32'(h_rem0[d][10]), 32'd2);
      check($sformatf("%s_rem0_c29_r%0d", tag, d), 32'(h_rem0[d][29]), 32'd1);
    end
  endtask

  typedef struct {
    logic [1:0] st;
    logic [1:0] cn;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] e_led;
    logic [1:0] e_done;
    logic [7:0] e_r0;
    logic [7:0] e_r1;
  } vec_t;

  vec_t vecs [10];

  initial begin
    resett   = 1'b1;
    start    = '0;
    cancel   = '0;
    duration = '0;

    // Idle-state vectors; expected outputs are for the following cycle.
    vecs[0] = '{2'b01, 2'b00, 8'd0, 8'd0, 2'b00, 2'b01, 8'd0, 8'd0};  // zero duration
    vecs[1] = '{2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 8'd0, 8'd0};  // done lasts one cycle
    vecs[2] = '{2'b11, 2'b11, 8'd5, 8'd5, 2'b00, 2'b00, 8'd0, 8'd0};  // start+cancel
    vecs[3] = '{2'b00, 2'b10, 8'd5, 8'd5, 2'b00, 2'b00, 8'd0, 8'd0};  // idle cancel
    vecs[4] = '{2'b10, 2'b00, 8'd9, 8'd4, 2'b10, 2'b00, 8'd0, 8'd4};  // ch1 arms
    vecs[5] = '{2'b00, 2'b10, 8'd9, 8'd9, 2'b00, 2'b00, 8'd0, 8'd0};  // ch1 cancelled
    vecs[6] = '{2'b11, 2'b00, 8'd0, 8'd0, 2'b00, 2'b11, 8'd0, 8'd0};  // both zero-duration
    vecs[7] = '{2'b00, 2'b00, 8'd0, 8'd0, 2'b00, 2'b00, 8'd0, 8'd0};
    vecs[8] = '{2'b01, 2'b00, 8'd7, 8'd0, 2'b01, 2'b00, 8'd7, 8'd0};  // ch0 arms
    vecs[9] = '{2'b00, 2'b01, 8'd1, 8'd0, 2'b00, 2'b00, 8'd0, 8'd0};  // ch0 cancelled

    do_reset();
    for (int v = 0; v < 10; v++) begin
      start    = vecs[v].st;
      cancel   = vecs[v].cn;
      duration = {vecs[v].d1, vecs[v].d0};
      step();
      for (int d = 0; d < 2; d++) begin
        check($sformatf("vec%0d_led_r%0d", v, d), 32'(led_of(d)), 32'(vecs[v].e_led));
        check($sformatf("vec%0d_done_r%0d", v, d), 32'(done_of(d)), 32'(vecs[v].e_done));
        check($sformatf("vec%0d_rem_r%0d", v, d), 32'(rem_of(d)),
              32'({vecs[v].e_r1, vecs[v].e_r0}));
      end
    end
    start  = '0;
    cancel = '0;

    // Basic run: ch0 for 3 ticks, ch1 for 2 ticks.
    scen_run(1'b1, -1, -1, 40, 1'b0);
    basic_checks("basic");

    // Cancel ch0 mid-run; ch1 keeps going.
    scen_run(1'b1, 15, -1, 40, 1'b0);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("cancel_done0_count_r%0d", d), 32'(count_done(d, 0, 40)), 32'd0);
      check($sformatf("cancel_led0_c16_r%0d", d), 32'(h_led[d][16][0]), 32'd0);
      check($sformatf("cancel_rem0_c16_r%0d", d), 32'(h_rem0[d][16]), 32'd0);
      check($sformatf("cancel_done1_cycle_r%0d", d), 32'(first_done(d, 1, 40)), 32'd20);
    end

    // Second start at cycle 25: ignored without retrigger, reload with it.
    // Reloaded 3 ticks fall at cycles 29, 39, 49 so done lands at 50.
    scen_run(1'b1, -1, 25, 65, 1'b0);
    check("retrig_done0_cycle_r0", 32'(first_done(0, 0, 65)), 32'd30);
    check("retrig_done0_count_r0", 32'(count_done(0, 0, 65)), 32'd1);
    check("retrig_rem0_c26_r1", 32'(h_rem0[1][26]), 32'd3);
    check("retrig_done0_cycle_r1", 32'(first_done(1, 0, 65)), 32'd50);
    check("retrig_done0_count_r1", 32'(count_done(1, 0, 65)), 32'd1);

    // Asynchronous reset between edges at cycle 12 of a run.
    do_reset();
    start    = 2'b01;
    duration = {8'd0, 8'd3};
    step();
    start = '0;
    for (int c = 1; c < 12; c++) step();
    check("pre_reset_led", 32'(led_a), 32'd1);
    #3;
    resett = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("async_led_r%0d", d), 32'(led_of(d)), 32'd0);
      check($sformatf("async_done_r%0d", d), 32'(done_of(d)), 32'd0);
      check($sformatf("async_rem_r%0d", d), 32'(rem_of(d)), 32'd0);
    end
    check("async_pcnt_r0", 32'(u_r0.pcnt), 32'd0);
    check("async_pcnt_r1", 32'(u_r1.pcnt), 32'd0);
    @(posedge clock);
    #1;
    resett = 1'b0;
    model_reset();
    compare_all();
    scen_run(1'b0, -1, -1, 40, 1'b0);
    basic_checks("post_reset");

    // Start held high for 50 cycles with duration 2.
    scen_run(1'b1, -1, -1, 75, 1'b1);
`ifdef MULTI_ONESHOT_EDGE_START_EN
    check("hold_done0_count_r0", 32'(count_done(0, 0, 75)), 32'd1);
    check("hold_led0_c21_r0", 32'(h_led[0][21][0]), 32'd0);
`else
    check("hold_done0_count_r0", 32'(count_done(0, 0, 75)), 32'd3);
    check("hold_led0_c21_r0", 32'(h_led[0][21][0]), 32'd1);
`endif
    check("hold_done0_first_r0", 32'(first_done(0, 0, 75)), 32'd20);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < CH; ch++) begin
        start[ch]  = ($urandom_range(0, 7) == 0);
        cancel[ch] = ($urandom_range(0, 15) == 0);
        duration[ch*W +: W] = W'($urandom_range(0, 5));
      end
      step();
    end
    start  = '0;
    cancel = '0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
